// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and default widths for the DMEM port-B arbiter.
//   owner_e     : which master (if any) a decision refers to
//   arb_state_e : port-B ownership FSM states
//   DMEM_B_ADDR_W / DMEM_B_DATA_W : default port-B geometry
package dmem_pkg;

  localparam int unsigned DMEM_B_ADDR_W = 7;
  localparam int unsigned DMEM_B_DATA_W = 256;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CCD,
    OWN_ACC
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CCD_OWN,
    ST_ACC_OWN
  } arb_state_e;

endpackage

// File: rtl/dmem_rdlat_pipe.sv
// dmem_rdlat_pipe: RD_LAT-deep valid shift register that tracks accelerator
// read beats through the RAM read latency.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset (drops everything in flight)
//   rd_beat : an accelerator read beat is presented to port B this cycle
//   rvalid  : read data for a beat issued RD_LAT cycles ago is on q_b
module dmem_rdlat_pipe #(
  parameter int unsigned RD_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rd_beat,
  output logic rvalid
);

  logic [RD_LAT-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= rd_beat;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign rvalid = stage[RD_LAT-1];

endmodule

// File: rtl/dmem_portb_arbiter.sv
// dmem_portb_arbiter: shares DMEM port B between the CCD image writer and
// the accelerator using burst-locked req/gnt arbitration.
//   clk, rst_n            : clock, asynchronous active-low reset
//   halt                  : CPU halted; no new grants are issued
//   ccd_req/addr/wdata    : CCD write master; ccd_gnt marks ownership
//   acc_req/we/addr/wdata : accelerator master; acc_gnt marks ownership
//   acc_rvalid/acc_rdata  : accelerator read return (RD_LAT after the beat)
//   address_b/data_b/rden_b/wren_b/q_b : RAM port B
// Build option: define DMEM_ARB_RR_EN for round-robin tie-breaking from IDLE;
// otherwise CCD has fixed priority over the accelerator.
module dmem_portb_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = DMEM_B_ADDR_W,
  parameter int unsigned DATA_W    = DMEM_B_DATA_W,
  parameter int unsigned BURST_MAX = 16,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              ccd_req,
  input  logic [ADDR_W-1:0] ccd_addr,
  input  logic [DATA_W-1:0] ccd_wdata,
  output logic              ccd_gnt,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  output logic [DATA_W-1:0] acc_rdata,
  output logic [ADDR_W-1:0] address_b,
  output logic [DATA_W-1:0] data_b,
  output logic              rden_b,
  output logic              wren_b,
  input  logic [DATA_W-1:0] q_b
);

  localparam int unsigned         CNT_W    = $clog2(BURST_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(BURST_MAX - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] beat_cnt;
  logic             ccd_beat;
  logic             acc_beat;
  logic             burst_end;
  owner_e           idle_pick;
  logic             take_ccd;
  logic             take_acc;

  assign ccd_beat  = ccd_gnt & ccd_req;
  assign acc_beat  = acc_gnt & acc_req;
  // The beat that brings the count to BURST_MAX is still issued; this flags it.
  assign burst_end = (ccd_beat | acc_beat) & (beat_cnt == CNT_LAST);

`ifdef DMEM_ARB_RR_EN
  owner_e last_served;

  always_comb begin
    idle_pick = OWN_NONE;
    if (ccd_req && acc_req) begin
      idle_pick = (last_served == OWN_CCD) ? OWN_ACC : OWN_CCD;
    end else if (ccd_req) begin
      idle_pick = OWN_CCD;
    end else if (acc_req) begin
      idle_pick = OWN_ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_served <= OWN_CCD;
    end else if (take_ccd) begin
      last_served <= OWN_CCD;
    end else if (take_acc) begin
      last_served <= OWN_ACC;
    end
  end
`else
  always_comb begin
    idle_pick = OWN_NONE;
    if (ccd_req) begin
      idle_pick = OWN_CCD;
    end else if (acc_req) begin
      idle_pick = OWN_ACC;
    end
  end
`endif

  // New-grant decisions; halt suppresses both the IDLE grant and the
  // end-of-burst hand-over.
  always_comb begin
    take_ccd = 1'b0;
    take_acc = 1'b0;
    unique case (state)
      ST_IDLE: begin
        take_ccd = ~halt & (idle_pick == OWN_CCD);
        take_acc = ~halt & (idle_pick == OWN_ACC);
      end
      ST_CCD_OWN: take_acc = burst_end & acc_req & ~halt;
      ST_ACC_OWN: take_ccd = burst_end & ccd_req & ~halt;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ccd_gnt  <= 1'b0;
      acc_gnt  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          beat_cnt <= '0;
          if (take_ccd) begin
            state   <= ST_CCD_OWN;
            ccd_gnt <= 1'b1;
          end else if (take_acc) begin
            state   <= ST_ACC_OWN;
            acc_gnt <= 1'b1;
          end
        end
        ST_CCD_OWN: begin
          if (!ccd_req) begin
            state    <= ST_IDLE;
            ccd_gnt  <= 1'b0;
            beat_cnt <= '0;
          end else if (burst_end) begin
            beat_cnt <= '0;
            if (take_acc) begin
              state   <= ST_ACC_OWN;
              ccd_gnt <= 1'b0;
              acc_gnt <= 1'b1;
            end else if (acc_req) begin
              // Hand-over blocked by halt: release the port instead.
              state   <= ST_IDLE;
              ccd_gnt <= 1'b0;
            end
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        ST_ACC_OWN: begin
          if (!acc_req) begin
            state    <= ST_IDLE;
            acc_gnt  <= 1'b0;
            beat_cnt <= '0;
          end else if (burst_end) begin
            beat_cnt <= '0;
            if (take_ccd) begin
              state   <= ST_CCD_OWN;
              acc_gnt <= 1'b0;
              ccd_gnt <= 1'b1;
            end else if (ccd_req) begin
              state   <= ST_IDLE;
              acc_gnt <= 1'b0;
            end
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          ccd_gnt  <= 1'b0;
          acc_gnt  <= 1'b0;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Port B carries the owner's beat; everything is zero when no beat occurs.
  always_comb begin
    address_b = '0;
    data_b    = '0;
    rden_b    = 1'b0;
    wren_b    = 1'b0;
    if (ccd_beat) begin
      address_b = ccd_addr;
      data_b    = ccd_wdata;
      wren_b    = 1'b1;
    end else if (acc_beat) begin
      address_b = acc_addr;
      data_b    = acc_wdata;
      wren_b    = acc_we;
      rden_b    = ~acc_we;
    end
  end

  dmem_rdlat_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rdlat_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_beat(acc_beat & ~acc_we),
    .rvalid (acc_rvalid)
  );

  assign acc_rdata = q_b;

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// tb_dmem_portb_arbiter: self-checking bench for dmem_portb_arbiter with a
// behavioural port-B RAM and a transaction-level reference model.
module tb_dmem_portb_arbiter;

  localparam int unsigned AW     = 7;
  localparam int unsigned DW     = 32;
  localparam int unsigned BURST  = 4;
  localparam int unsigned RD_LAT = 1;

  logic          clk;
  logic          rst_n;
  logic          halt;
  logic          ccd_req;
  logic [AW-1:0] ccd_addr;
  logic [DW-1:0] ccd_wdata;
  logic          ccd_gnt;
  logic          acc_req;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;
  logic          acc_gnt;
  logic          acc_rvalid;
  logic [DW-1:0] acc_rdata;
  logic [AW-1:0] address_b;
  logic [DW-1:0] data_b;
  logic          rden_b;
  logic          wren_b;
  logic [DW-1:0] q_b;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_portb_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BURST), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt),
    .ccd_req(ccd_req), .ccd_addr(ccd_addr), .ccd_wdata(ccd_wdata), .ccd_gnt(ccd_gnt),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid), .acc_rdata(acc_rdata),
    .address_b(address_b), .data_b(data_b), .rden_b(rden_b), .wren_b(wren_b), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port-B RAM with RD_LAT read latency
  logic [DW-1:0] ram    [128];
  logic [DW-1:0] q_pipe [RD_LAT];
  always @(posedge clk) begin
    if (wren_b) ram[address_b] <= data_b;
    for (int i = RD_LAT - 1; i > 0; i--) q_pipe[i] <= q_pipe[i-1];
    if (rden_b) q_pipe[0] <= ram[address_b];
  end
  assign q_b = q_pipe[RD_LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    return 32'hC0DE_0000 + 32'(k);
  endfunction

  function automatic int tie_winner(input int last);
`ifdef DMEM_ARB_RR_EN
    return (last == 1) ? 2 : 1;
`else
    return 1;
`endif
  endfunction

  // Reference model: owner 0=none 1=ccd 2=acc, beats served in current
  // ownership, last-granted master, expected read returns, reference memory.
  int            m_owner;
  int            m_beats;
  int            m_last;
  bit            exp_rv [RD_LAT];
  logic [DW-1:0] exp_rd [RD_LAT];
  logic [DW-1:0] ref_mem[128];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = 0;
      m_beats = 0;
      m_last  = 1;
      for (int i = 0; i < RD_LAT; i++) exp_rv[i] = 1'b0;
    end else begin
      bit bc, ba, mine, oreq;
      int other;
      bc = (m_owner == 1) && ccd_req;
      ba = (m_owner == 2) && acc_req;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        exp_rv[i] = exp_rv[i-1];
        exp_rd[i] = exp_rd[i-1];
      end
      exp_rv[0] = ba && !acc_we;
      exp_rd[0] = ref_mem[acc_addr];
      if (bc) ref_mem[ccd_addr] = ccd_wdata;
      if (ba && acc_we) ref_mem[acc_addr] = acc_wdata;
      if (m_owner == 0) begin
        if (!halt && (ccd_req || acc_req)) begin
          m_owner = (ccd_req && acc_req) ? tie_winner(m_last) : (ccd_req ? 1 : 2);
          m_last  = m_owner;
          m_beats = 0;
        end
      end else begin
        mine  = (m_owner == 1) ? ccd_req : acc_req;
        other = 3 - m_owner;
        oreq  = (other == 1) ? ccd_req : acc_req;
        if (!mine) begin
          m_owner = 0;
          m_beats = 0;
        end else begin
          m_beats++;
          if (m_beats == BURST) begin
            m_beats = 0;
            if (oreq) begin
              if (halt) m_owner = 0;
              else begin
                m_owner = other;
                m_last  = other;
              end
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit bc, ba;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      bc = (m_owner == 1) && ccd_req;
      ba = (m_owner == 2) && acc_req;
      ea = bc ? ccd_addr : (ba ? acc_addr : '0);
      ed = bc ? ccd_wdata : (ba ? acc_wdata : '0);
      chk("m_ccd_gnt", ccd_gnt, m_owner == 1);
      chk("m_acc_gnt", acc_gnt, m_owner == 2);
      chk("m_wren_b", wren_b, bc || (ba && acc_we));
      chk("m_rden_b", rden_b, ba && !acc_we);
      chk("m_address_b", address_b, ea);
      if (!ba || acc_we) chk("m_data_b", data_b, ed);
      chk("m_acc_rvalid", acc_rvalid, exp_rv[RD_LAT-1]);
      if (exp_rv[RD_LAT-1]) chk("m_acc_rdata", acc_rdata, exp_rd[RD_LAT-1]);
    end
  end

  typedef struct {
    bit cr, ar, we, hl;
    bit e_cg, e_ag, e_wr, e_rd;
    logic [AW-1:0] e_addr;
  } vec_t;
  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first_g, nw, nb, own, beats, got, i, nrv, e_own;
    int beat_cyc[3];
    int rv_cyc[3];

    for (int k = 0; k < 128; k++) begin
      ram[k]     = '0;
      ref_mem[k] = '0;
    end
    for (int k = 0; k < RD_LAT; k++) q_pipe[k] = '0;
    rst_n = 1'b0; halt = 1'b0;
    ccd_req = 1'b0; ccd_addr = '0; ccd_wdata = '0;
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ccd_gnt", ccd_gnt, 0);
    chk("rst_acc_gnt", acc_gnt, 0);
    chk("rst_rvalid", acc_rvalid, 0);
    chk("rst_wren", wren_b, 0);
    chk("rst_rden", rden_b, 0);
    chk("rst_addr", address_b, 0);
    rst_n = 1'b1;

    //        cr ar we hl  cg ag wr rd  addr
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 7'd0};
    tbl[1]  = '{1, 0, 0, 0, 1, 0, 1, 0, 7'd1};
    tbl[2]  = '{1, 0, 0, 0, 1, 0, 1, 0, 7'd2};
    tbl[3]  = '{1, 1, 0, 0, 1, 0, 1, 0, 7'd3};
    tbl[4]  = '{1, 1, 0, 0, 1, 0, 1, 0, 7'd4};
    tbl[5]  = '{1, 1, 0, 0, 0, 1, 0, 1, 7'd69};
    tbl[6]  = '{0, 1, 1, 0, 0, 1, 1, 0, 7'd70};
    tbl[7]  = '{1, 0, 0, 0, 0, 1, 0, 0, 7'd0};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 0, 7'd0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 7'd0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 7'd0};
    for (int r = 0; r < 11; r++) begin
      ccd_req = tbl[r].cr; acc_req = tbl[r].ar; acc_we = tbl[r].we; halt = tbl[r].hl;
      ccd_addr = AW'(r); acc_addr = AW'(r + 64);
      ccd_wdata = $urandom; acc_wdata = $urandom;
      @(negedge clk);
      chk("tbl_ccd_gnt", ccd_gnt, tbl[r].e_cg);
      chk("tbl_acc_gnt", acc_gnt, tbl[r].e_ag);
      chk("tbl_wren", wren_b, tbl[r].e_wr);
      chk("tbl_rden", rden_b, tbl[r].e_rd);
      chk("tbl_addr", address_b, tbl[r].e_addr);
      tick();
    end

    // Simultaneous request from IDLE; the last grant went to the CCD
    ccd_req = 1; acc_req = 1; acc_we = 1;
    @(negedge clk);
    tick();
    @(negedge clk);
`ifdef DMEM_ARB_RR_EN
    chk("tie_acc_wins", {ccd_gnt, acc_gnt}, 2'b01);
`else
    chk("tie_ccd_wins", {ccd_gnt, acc_gnt}, 2'b10);
`endif
    tick();
    ccd_req = 0; acc_req = 0;
    tick(); tick();

    // CCD burst of 4 at 0x10..0x13
    ccd_req = 1; i = 0; first_g = -1; nw = 0;
    for (int c = 0; c < 20 && i < 4; c++) begin
      ccd_addr = 7'h10 + AW'(i); ccd_wdata = pat(i);
      @(negedge clk);
      if (wren_b) nw++;
      if (ccd_gnt) begin
        if (first_g < 0) first_g = c;
        i++;
      end
      tick();
    end
    ccd_req = 0;
    chk("ccd_beats", i, 4);
    chk("ccd_gnt_latency", first_g, 1);
    chk("ccd_wren_cycles", nw, 4);
    tick();
    for (int k = 0; k < 4; k++) chk("ccd_ram_data", ram[16 + k], pat(k));

    // Accelerator read burst of 3 at 0x10
    i = 0; nrv = 0; acc_we = 0;
    for (int k = 0; k < 3; k++) begin beat_cyc[k] = -100; rv_cyc[k] = -1; end
    for (int c = 0; c < 10; c++) begin
      acc_req = (i < 3); acc_addr = 7'h10 + AW'(i);
      @(negedge clk);
      if (acc_req && acc_gnt) begin beat_cyc[i] = c; i++; end
      if (acc_rvalid) begin
        if (nrv < 3) begin
          rv_cyc[nrv] = c;
          chk("rd_data", acc_rdata, pat(nrv));
        end
        nrv++;
      end
      tick();
    end
    acc_req = 0;
    chk("rd_beats", i, 3);
    chk("rd_rvalids", nrv, 3);
    for (int k = 0; k < 3; k++) chk("rd_latency", rv_cyc[k] - beat_cyc[k], RD_LAT);
    chk("rd_back2back", rv_cyc[2] - rv_cyc[0], 2);

    // Both held: ownership alternates every BURST beats, no idle gap
    ccd_req = 1; acc_req = 1; acc_we = 1; beats = 0;
    for (int c = 0; c < 26; c++) begin
      ccd_addr = AW'($urandom); acc_addr = AW'($urandom);
      ccd_wdata = $urandom; acc_wdata = $urandom;
      @(negedge clk);
      own   = ccd_gnt ? 1 : (acc_gnt ? 2 : 0);
      e_own = (c == 0) ? 0 : ((((c - 1) / BURST) % 2 == 0) ? 1 : 2);
      chk("alt_owner", own, e_own);
      if (own != 0) beats++;
      tick();
    end
    chk("alt_total_beats", beats, 25);
    ccd_req = 0; acc_req = 0;
    tick(); tick(); tick();

    // halt mid CCD burst with accel pending
    ccd_req = 1; acc_req = 0; acc_we = 1; halt = 0; nb = 0;
    for (int c = 0; c < 14; c++) begin
      ccd_addr = AW'(c); ccd_wdata = $urandom;
      @(negedge clk);
      if (halt) chk("halt_acc_gnt", acc_gnt, 0);
      if (ccd_gnt) nb++;
      tick();
      if (nb >= 2) begin halt = 1; acc_req = 1; end
    end
    chk("halt_ccd_beats", nb, BURST);
    halt = 0; ccd_req = 0;
    @(negedge clk);
    chk("halt_idle_gnt", {ccd_gnt, acc_gnt}, 2'b00);
    tick();
    @(negedge clk);
    chk("halt_release_gnt", acc_gnt, 1);
    tick();
    acc_req = 0;
    tick(); tick();

    // Async reset during an accel read with rvalid outstanding
    acc_req = 1; acc_we = 0; acc_addr = 7'h10; got = 0;
    for (int c = 0; c < 6 && got == 0; c++) begin
      @(negedge clk);
      if (acc_gnt) got = 1;
      else tick();
    end
    chk("rst_wait_gnt", got, 1);
    @(posedge clk);
    #2;
    chk("rst_rvalid_before", acc_rvalid, 1);
    rst_n = 0;
    #1;
    chk("rst_mid_ccd_gnt", ccd_gnt, 0);
    chk("rst_mid_acc_gnt", acc_gnt, 0);
    chk("rst_mid_rvalid", acc_rvalid, 0);
    chk("rst_mid_rden", rden_b, 0);
    chk("rst_mid_wren", wren_b, 0);
    chk("rst_mid_addr", address_b, 0);
    acc_req = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_rvalid", acc_rvalid, 0);
      tick();
    end

    // Randomized traffic against the reference model
    for (int c = 0; c < 2000; c++) begin
      ccd_req   = ($urandom_range(0, 9) < 6);
      acc_req   = ($urandom_range(0, 9) < 6);
      acc_we    = $urandom_range(0, 1);
      halt      = ($urandom_range(0, 15) == 0);
      ccd_addr  = AW'($urandom);
      acc_addr  = AW'($urandom);
      ccd_wdata = $urandom;
      acc_wdata = $urandom;
      tick();
    end

    ccd_req = 0; acc_req = 0; halt = 0;
    repeat (4) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
